// File: rtl/fpu_addsub_issue16.sv
// Operand issue FIFO for the FP16 add/sub datapath with NaN/Inf pre-classification.
// Optional macro FPU_ISSUE_FTZ_EN flushes subnormal operands to signed zero at push time.
module fpu_addsub_issue16 #(
   parameter int DEPTH = 4,
   parameter int CNTW  = 16
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            in_sub,
   input  logic [15:0]     in_a,
   input  logic [15:0]     in_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            sub,
   output logic [15:0]     fpuIn1,
   output logic [15:0]     fpuIn2,
   output logic            special,
   output logic [15:0]     specialResult,
   output logic            invalidOp,
   output logic [CNTW-1:0] issueCount
);

   localparam int AW = $clog2(DEPTH);

   function automatic logic is_nan(input logic [15:0] x);
      return (x[14:10] == 5'h1F) && (x[9:0] != 10'h000);
   endfunction

   function automatic logic is_inf(input logic [15:0] x);
      return (x[14:10] == 5'h1F) && (x[9:0] == 10'h000);
   endfunction

`ifdef FPU_ISSUE_FTZ_EN
   function automatic logic [15:0] ftz(input logic [15:0] x);
      logic [15:0] r;
      r = x;
      if ((x[14:10] == 5'h00) && (x[9:0] != 10'h000)) begin
         r = {x[15], 15'h0000};
      end else begin
         r = x;
      end
      return r;
   endfunction
`endif

   logic [32:0]   mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW:0]   count_r;
   logic [CNTW-1:0] issue_count_r;
   logic          push_s;
   logic          pop_s;
   logic [15:0]   a_store_s;
   logic [15:0]   b_store_s;
   logic [32:0]   head_s;
   logic          eff_b_s;

`ifdef FPU_ISSUE_FTZ_EN
   assign a_store_s = ftz(in_a);
   assign b_store_s = ftz(in_b);
`else
   assign a_store_s = in_a;
   assign b_store_s = in_b;
`endif

   // Flags derive only from registered occupancy; no path from out_ready to in_ready.
   assign in_ready  = (count_r != (AW+1)'(DEPTH));
   assign out_valid = (count_r != (AW+1)'(0));
   assign push_s    = in_valid && in_ready;
   assign pop_s     = out_valid && out_ready;

   // Entry storage, intentionally not reset; a flushed push is discarded.
   always_ff @(posedge clock) begin
      if (push_s && !flush) begin
         mem_r[wr_ptr_r] <= {in_sub, a_store_s, b_store_s};
      end
   end

   // Pointer and occupancy bookkeeping; flush beats push and pop.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_r <= AW'(0);
         rd_ptr_r <= AW'(0);
         count_r  <= (AW+1)'(0);
      end else if (flush) begin
         wr_ptr_r <= AW'(0);
         rd_ptr_r <= AW'(0);
         count_r  <= (AW+1)'(0);
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
         if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + (AW+1)'(1);
            2'b01:   count_r <= count_r - (AW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Completed-issue counter; a pop coinciding with flush does not count.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         issue_count_r <= {CNTW{1'b0}};
      end else if (pop_s && !flush) begin
         issue_count_r <= issue_count_r + CNTW'(1);
      end
   end

   assign issueCount = issue_count_r;
   assign head_s     = mem_r[rd_ptr_r];
   assign sub        = head_s[32];
   assign fpuIn1     = head_s[31:16];
   assign fpuIn2     = head_s[15:0];
   assign eff_b_s    = fpuIn2[15] ^ sub;

   // Special-case classification of the head entry for the downstream bypass mux.
   always_comb begin
      special       = 1'b0;
      specialResult = 16'h0000;
      invalidOp     = 1'b0;
      if (is_nan(fpuIn1) || is_nan(fpuIn2)) begin
         special       = 1'b1;
         specialResult = 16'h7E00;
         invalidOp     = 1'b1;
      end else if (is_inf(fpuIn1) && is_inf(fpuIn2)) begin
         special = 1'b1;
         if (fpuIn1[15] != eff_b_s) begin
            specialResult = 16'h7E00;
            invalidOp     = 1'b1;
         end else begin
            specialResult = {fpuIn1[15], 5'h1F, 10'h000};
            invalidOp     = 1'b0;
         end
      end else if (is_inf(fpuIn1)) begin
         special       = 1'b1;
         specialResult = {fpuIn1[15], 5'h1F, 10'h000};
      end else if (is_inf(fpuIn2)) begin
         special       = 1'b1;
         specialResult = {eff_b_s, 5'h1F, 10'h000};
      end else begin
         special       = 1'b0;
         specialResult = 16'h0000;
      end
   end

endmodule
